axi2mem: RTL and testbench
==========================

AXI2MEM -- requirements
Module: axi2mem

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-002 SHALL have parameter MAX_BEATS, default 8, the largest supported burst length (arlen/awlen + 1).
REQ-003 SHALL have port clk, input, 1, the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have AXI4 slave AR ports: s_arvalid in 1, s_arready out 1, s_arid in ID_W, s_araddr in 32, s_arlen in 8, s_arsize in 3, s_arburst in 2.
REQ-006 SHALL have AXI4 slave R ports: s_rvalid out 1, s_rready in 1, s_rid out ID_W, s_rdata out 64, s_rresp out 2, s_rlast out 1.
REQ-007 SHALL have AXI4 slave AW ports (s_awvalid/ready/id/addr/len/size/burst), with widths as AR.
REQ-008 SHALL have AXI4 slave W ports: s_wvalid in 1, s_wready out 1, s_wdata in 64, s_wstrb in 8, s_wlast in 1.
REQ-009 SHALL have AXI4 slave B ports: s_bvalid out 1, s_bready in 1, s_bid out ID_W, s_bresp out 2.
REQ-010 SHALL have memory read ports: m_r_req out 1, m_r_addr out 32, m_r_size out 3, m_r_rdy in 1, m_re_data in 64, m_re_valid in 1.
REQ-011 SHALL have memory write ports: m_w_req out 1, m_w_addr out 32, m_w_data out 64, m_w_strb out 8, m_w_rdy in 1.

Function
REQ-012 SHALL run independent read and write FSMs; a read and a write burst may be in progress at the same time.
REQ-013 SHALL implement the read FSM as R_IDLE -> R_REQ -> R_WAIT -> R_SEND, then back to R_REQ if beats remain, else to R_IDLE.
REQ-014 SHALL drive s_arready=1 only in R_IDLE; the AR handshake latches id, addr, len, size and clears the beat counter.
REQ-015 SHALL hold m_r_req=1 in R_REQ, and move to R_WAIT on the cycle m_r_rdy=1.
REQ-016 SHALL capture m_re_data in R_WAIT when m_re_valid=1, and assert s_rvalid in R_SEND from the next cycle.
REQ-017 SHALL hold s_rdata, s_rid, s_rresp and s_rlast stable while s_rvalid=1 and s_rready=0.
REQ-018 SHALL assert s_rlast when the beat counter equals the latched len.
REQ-019 SHALL implement the write FSM as W_IDLE -> W_DATA -> W_REQ, then back to W_DATA if beats remain, else to W_RESP, then W_IDLE.
REQ-020 SHALL drive s_awready=1 only in W_IDLE and s_wready=1 only in W_DATA; each W handshake registers data and strb.
REQ-021 SHALL hold m_w_req=1 in W_REQ until m_w_rdy=1.
REQ-022 SHALL assert s_bvalid in W_RESP until s_bready=1, then return to W_IDLE.
REQ-023 SHALL end a write burst on beat count == awlen, regardless of s_wlast.
REQ-024 SHALL, with an early s_wlast, still expect the remaining beats.
REQ-025 SHALL compute the next beat address as addr + (1 << size), modulo 2^32 (wraps at 0xFFFF_FFFF).
REQ-026 SHALL give minimum read latency of 3 cycles from the AR handshake to the first s_rvalid, when m_r_rdy and m_re_valid are each 1 on the first cycle they are sampled.
REQ-027 SHALL return rresp and bresp OKAY (2'b00) unless REQ-031 applies.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously), force both FSMs to IDLE and clear all counters and registers.
REQ-029 SHALL reset outputs to: s_arready=1, s_awready=1, all other valid/req/ready/last outputs 0, all data/addr/id/resp outputs 0.
REQ-030 SHALL drop any burst or memory request in flight when reset is asserted mid-operation, with no further response issued.

Configuration
REQ-031 SHALL, with AXI2MEM_SLVERR_EN defined, flag a burst as errored when burst != INCR, size > 3, or len >= MAX_BEATS; every R beat and the B response then carry SLVERR (2'b10), no memory request is issued, and the full beat count is still handshaken.
REQ-032 SHALL, without AXI2MEM_SLVERR_EN, treat every burst as INCR, with size and len used as given (truncated to counter width), and always answer OKAY.

Structure
REQ-033 SHALL take the AXI width constants and resp/burst encodings (OKAY, SLVERR, INCR), plus the read and write FSM state enums, from the shared AXI define package.
REQ-034 SHALL factor out one sub-module, axi2mem_addr_gen (latched addr/size/len, beat counter, next-address and last computation), instantiated once per channel.

Verification
REQ-035 SHALL test single read: AR addr 0x8000_0000, len 0, size 3, id 5, with memory returning 0x1122334455667788 -> one R beat with that data, rid 5, rlast=1, rresp 0.
REQ-036 SHALL test INCR read: len 3, size 2 at 0x100 -> m_r_addr sequence 0x100, 0x104, 0x108, 0x10C, with rlast on the 4th beat only.
REQ-037 SHALL test write burst: len 1 at 0x200, wstrb 0xFF then 0x0F -> m_w_addr 0x200/0x208 with matching strb, then a single B with bid echoed and bresp 0.
REQ-038 SHALL test backpressure and concurrency: s_rready held 0 for 5 cycles -> rdata stable; an overlapping write burst completes independently.
REQ-039 SHALL test errors with AXI2MEM_SLVERR_EN: arburst WRAP, len 1 -> two R beats with rresp 2'b10 and no m_r_req.
REQ-040 SHALL test reset mid-burst: rst_n low during beat 2 of 4 -> outputs take reset values immediately, and the next AR is accepted cleanly.

Source files
------------

// File: rtl/axi2mem_pkg.sv
// rtl/axi2mem_pkg.sv - shared AXI widths, encodings and FSM state enums for axi2mem
package axi2mem_pkg;

   localparam int AXI_ADDR_W  = 32;
   localparam int AXI_DATA_W  = 64;
   localparam int AXI_STRB_W  = 8;
   localparam int AXI_LEN_W   = 8;
   localparam int AXI_SIZE_W  = 3;
   localparam int AXI_BURST_W = 2;
   localparam int AXI_RESP_W  = 2;

   localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
   localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;
   localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REQ  = 2'd1,
      R_WAIT = 2'd2,
      R_SEND = 2'd3
   } r_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_REQ  = 2'd2,
      W_RESP = 2'd3
   } w_state_e;

   // A burst is unsupported if it is not INCR, wider than the 64-bit bus,
   // or longer than the beat counter was sized for.
   function automatic logic burst_bad(input logic [AXI_BURST_W-1:0] burst,
                                      input logic [AXI_SIZE_W-1:0]  size,
                                      input logic [AXI_LEN_W-1:0]   len,
                                      input int                     max_beats);
      return (burst != BURST_INCR) || (size > 3'd3) ||
             (int'({24'd0, len}) >= max_beats);
   endfunction

endpackage

// File: rtl/axi2mem_addr_gen.sv
// rtl/axi2mem_addr_gen.sv - per-channel burst address and beat counter
module axi2mem_addr_gen
   import axi2mem_pkg::*;
#(
   parameter int LEN_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [AXI_ADDR_W-1:0] addr_i,
   input  logic [AXI_SIZE_W-1:0] size_i,
   input  logic [LEN_W-1:0]      len_i,
   input  logic                  step_i,
   output logic [AXI_ADDR_W-1:0] addr_o,
   output logic [AXI_SIZE_W-1:0] size_o,
   output logic                  last_o,
   output logic                  last_next_o
);

   logic [AXI_ADDR_W-1:0] addr_q, addr_d;
   logic [AXI_SIZE_W-1:0] size_q;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      cnt_q, cnt_d;

   // Address wraps naturally modulo 2^32 through the adder width.
   assign addr_d      = addr_q + (AXI_ADDR_W'(1) << size_q);
   assign cnt_d       = cnt_q + LEN_W'(1);
   assign addr_o      = addr_q;
   assign size_o      = size_q;
   assign last_o      = (cnt_q == len_q);
   assign last_next_o = (cnt_d == len_q);

   // Latch burst parameters on the address handshake, advance once per beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         size_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else if (load_i) begin
         addr_q <= addr_i;
         size_q <= size_i;
         len_q  <= len_i;
         cnt_q  <= '0;
      end else if (step_i) begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/axi2mem.sv
// rtl/axi2mem.sv - AXI4 slave to simple memory port bridge; optional AXI2MEM_SLVERR_EN
module axi2mem
   import axi2mem_pkg::*;
#(
   parameter int ID_W      = 4,
   parameter int MAX_BEATS = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   s_arvalid,
   output logic                   s_arready,
   input  logic [ID_W-1:0]        s_arid,
   input  logic [AXI_ADDR_W-1:0]  s_araddr,
   input  logic [AXI_LEN_W-1:0]   s_arlen,
   input  logic [AXI_SIZE_W-1:0]  s_arsize,
   input  logic [AXI_BURST_W-1:0] s_arburst,
   output logic                   s_rvalid,
   input  logic                   s_rready,
   output logic [ID_W-1:0]        s_rid,
   output logic [AXI_DATA_W-1:0]  s_rdata,
   output logic [AXI_RESP_W-1:0]  s_rresp,
   output logic                   s_rlast,
   input  logic                   s_awvalid,
   output logic                   s_awready,
   input  logic [ID_W-1:0]        s_awid,
   input  logic [AXI_ADDR_W-1:0]  s_awaddr,
   input  logic [AXI_LEN_W-1:0]   s_awlen,
   input  logic [AXI_SIZE_W-1:0]  s_awsize,
   input  logic [AXI_BURST_W-1:0] s_awburst,
   input  logic                   s_wvalid,
   output logic                   s_wready,
   input  logic [AXI_DATA_W-1:0]  s_wdata,
   input  logic [AXI_STRB_W-1:0]  s_wstrb,
   input  logic                   s_wlast,
   output logic                   s_bvalid,
   input  logic                   s_bready,
   output logic [ID_W-1:0]        s_bid,
   output logic [AXI_RESP_W-1:0]  s_bresp,
   output logic                   m_r_req,
   output logic [AXI_ADDR_W-1:0]  m_r_addr,
   output logic [AXI_SIZE_W-1:0]  m_r_size,
   input  logic                   m_r_rdy,
   input  logic [AXI_DATA_W-1:0]  m_re_data,
   input  logic                   m_re_valid,
   output logic                   m_w_req,
   output logic [AXI_ADDR_W-1:0]  m_w_addr,
   output logic [AXI_DATA_W-1:0]  m_w_data,
   output logic [AXI_STRB_W-1:0]  m_w_strb,
   input  logic                   m_w_rdy
);

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
`ifdef AXI2MEM_SLVERR_EN
   // Errored bursts may be up to 256 beats long, so count the full len.
   localparam int LEN_W = AXI_LEN_W;
`else
   localparam int LEN_W = CNT_W;
`endif

   // Read channel state
   r_state_e              r_state_q;
   logic                  arready_q, rvalid_q, rlast_q, m_r_req_q, rd_err_q;
   logic [AXI_RESP_W-1:0] rresp_q;
   logic [ID_W-1:0]       rid_q;
   logic [AXI_DATA_W-1:0] rdata_q;
   logic                  rd_load, rd_step, rd_last, rd_last_next, rd_bad;

   // Write channel state
   w_state_e              w_state_q;
   logic                  awready_q, wready_q, bvalid_q, m_w_req_q, wr_err_q;
   logic [AXI_RESP_W-1:0] bresp_q;
   logic [ID_W-1:0]       bid_q;
   logic [AXI_DATA_W-1:0] wdata_q;
   logic [AXI_STRB_W-1:0] wstrb_q;
   logic                  wr_load, wr_step, wr_last, wr_last_next, wr_bad;
   logic [AXI_SIZE_W-1:0] wr_size;

`ifdef AXI2MEM_SLVERR_EN
   assign rd_bad = burst_bad(s_arburst, s_arsize, s_arlen, MAX_BEATS);
   assign wr_bad = burst_bad(s_awburst, s_awsize, s_awlen, MAX_BEATS);
`else
   assign rd_bad = 1'b0;
   assign wr_bad = 1'b0;
`endif

   // Burst type, upper len bits and wlast do not steer the datapath.
   logic unused_in;
   assign unused_in = ^{s_wlast, s_arburst, s_awburst, s_arlen, s_awlen, wr_size};

   assign rd_load = (r_state_q == R_IDLE) && s_arvalid;
   assign rd_step = (r_state_q == R_SEND) && s_rready && !rd_last;
   assign wr_load = (w_state_q == W_IDLE) && s_awvalid;
   assign wr_step = ((w_state_q == W_DATA) && s_wvalid && wr_err_q && !wr_last) ||
                    ((w_state_q == W_REQ) && m_w_rdy && !wr_last);

   axi2mem_addr_gen #(.LEN_W(LEN_W)) u_rd_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (rd_load),
      .addr_i     (s_araddr),
      .size_i     (s_arsize),
      .len_i      (s_arlen[LEN_W-1:0]),
      .step_i     (rd_step),
      .addr_o     (m_r_addr),
      .size_o     (m_r_size),
      .last_o     (rd_last),
      .last_next_o(rd_last_next)
   );

   axi2mem_addr_gen #(.LEN_W(LEN_W)) u_wr_gen (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (wr_load),
      .addr_i     (s_awaddr),
      .size_i     (s_awsize),
      .len_i      (s_awlen[LEN_W-1:0]),
      .step_i     (wr_step),
      .addr_o     (m_w_addr),
      .size_o     (wr_size),
      .last_o     (wr_last),
      .last_next_o(wr_last_next)
   );

   assign s_arready = arready_q;
   assign s_rvalid  = rvalid_q;
   assign s_rid     = rid_q;
   assign s_rdata   = rdata_q;
   assign s_rresp   = rresp_q;
   assign s_rlast   = rlast_q;
   assign m_r_req   = m_r_req_q;

   assign s_awready = awready_q;
   assign s_wready  = wready_q;
   assign s_bvalid  = bvalid_q;
   assign s_bid     = bid_q;
   assign s_bresp   = bresp_q;
   assign m_w_req   = m_w_req_q;
   assign m_w_data  = wdata_q;
   assign m_w_strb  = wstrb_q;

   // Read FSM: one memory request and one R beat per iteration; errored
   // bursts skip memory and stream SLVERR beats straight from R_SEND.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         m_r_req_q <= 1'b0;
         rd_err_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rid_q     <= '0;
         rdata_q   <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (s_arvalid) begin
                  arready_q <= 1'b0;
                  rid_q     <= s_arid;
                  rd_err_q  <= rd_bad;
                  if (rd_bad) begin
                     r_state_q <= R_SEND;
                     rvalid_q  <= 1'b1;
                     rdata_q   <= '0;
                     rresp_q   <= RESP_SLVERR;
                     rlast_q   <= (s_arlen[LEN_W-1:0] == '0);
                  end else begin
                     r_state_q <= R_REQ;
                     m_r_req_q <= 1'b1;
                  end
               end
            end
            R_REQ: begin
               if (m_r_rdy) begin
                  m_r_req_q <= 1'b0;
                  r_state_q <= R_WAIT;
               end
            end
            R_WAIT: begin
               if (m_re_valid) begin
                  rdata_q   <= m_re_data;
                  rresp_q   <= RESP_OKAY;
                  rlast_q   <= rd_last;
                  rvalid_q  <= 1'b1;
                  r_state_q <= R_SEND;
               end
            end
            R_SEND: begin
               if (s_rready) begin
                  if (rd_last) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state_q <= R_IDLE;
                  end else if (rd_err_q) begin
                     rlast_q <= rd_last_next;
                  end else begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     m_r_req_q <= 1'b1;
                     r_state_q <= R_REQ;
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // Write FSM: accept one W beat, push it to memory, repeat until the
   // counter reaches awlen (wlast is ignored), then answer on B.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         m_w_req_q <= 1'b0;
         wr_err_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (s_awvalid) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  bid_q     <= s_awid;
                  wr_err_q  <= wr_bad;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (s_wvalid) begin
                  wdata_q <= s_wdata;
                  wstrb_q <= s_wstrb;
                  if (!wr_err_q) begin
                     wready_q  <= 1'b0;
                     m_w_req_q <= 1'b1;
                     w_state_q <= W_REQ;
                  end else if (wr_last) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= RESP_SLVERR;
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_REQ: begin
               if (m_w_rdy) begin
                  m_w_req_q <= 1'b0;
                  if (wr_last) begin
                     bvalid_q  <= 1'b1;
                     bresp_q   <= RESP_OKAY;
                     w_state_q <= W_RESP;
                  end else begin
                     wready_q  <= 1'b1;
                     w_state_q <= W_DATA;
                  end
               end
            end
            W_RESP: begin
               if (s_bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi2mem.sv
// tb/tb_axi2mem.sv - directed self-checking bench for axi2mem
module tb_axi2mem;

   logic        clk, rst_n;
   logic        s_arvalid, s_arready;
   logic [3:0]  s_arid;
   logic [31:0] s_araddr;
   logic [7:0]  s_arlen;
   logic [2:0]  s_arsize;
   logic [1:0]  s_arburst;
   logic        s_rvalid, s_rready, s_rlast;
   logic [3:0]  s_rid;
   logic [63:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_awvalid, s_awready;
   logic [3:0]  s_awid;
   logic [31:0] s_awaddr;
   logic [7:0]  s_awlen;
   logic [2:0]  s_awsize;
   logic [1:0]  s_awburst;
   logic        s_wvalid, s_wready, s_wlast;
   logic [63:0] s_wdata;
   logic [7:0]  s_wstrb;
   logic        s_bvalid, s_bready;
   logic [3:0]  s_bid;
   logic [1:0]  s_bresp;
   logic        m_r_req, m_r_rdy, m_re_valid;
   logic [31:0] m_r_addr;
   logic [2:0]  m_r_size;
   logic [63:0] m_re_data;
   logic        m_w_req, m_w_rdy;
   logic [31:0] m_w_addr;
   logic [63:0] m_w_data;
   logic [7:0]  m_w_strb;

   axi2mem #(.ID_W(4), .MAX_BEATS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
      .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
      .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
      .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_wlast(s_wlast),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
      .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_size(m_r_size), .m_r_rdy(m_r_rdy),
      .m_re_data(m_re_data), .m_re_valid(m_re_valid),
      .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
      .m_w_rdy(m_w_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Memory contents model: one fixed word, everything else derived from the address.
   function automatic logic [63:0] mem_fn(input logic [31:0] a);
      if (a == 32'h8000_0000) return 64'h1122_3344_5566_7788;
      return {~a, a};
   endfunction

   function automatic logic [63:0] wd_fn(input logic [3:0] id, input int i);
      return {16'hCAFE, 12'h000, id, 32'(i)};
   endfunction

   logic [31:0] mr_addr_q[$];
   logic [31:0] mw_addr_q[$];
   logic [63:0] mw_data_q[$];
   logic [7:0]  mw_strb_q[$];
   logic [63:0] r_data_q[$];
   logic [3:0]  r_id_q[$];
   logic [1:0]  r_resp_q[$];
   logic        r_last_q[$];
   int rd_gap = 0;
   int wr_gap = 0;

   // Read memory: grants m_r_rdy after rd_gap waiting cycles, data valid immediately.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (m_r_req) begin
            if (cnt >= rd_gap) begin
               m_r_rdy   = 1'b1;
               m_re_data = mem_fn(m_r_addr);
               mr_addr_q.push_back(m_r_addr);
            end else begin
               m_r_rdy = 1'b0;
               cnt++;
            end
         end else begin
            m_r_rdy = 1'b0;
            cnt = 0;
         end
      end
   end

   // Write memory: grants m_w_rdy after wr_gap waiting cycles and logs the beat.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk);
         if (m_w_req) begin
            if (cnt >= wr_gap) begin
               m_w_rdy = 1'b1;
               mw_addr_q.push_back(m_w_addr);
               mw_data_q.push_back(m_w_data);
               mw_strb_q.push_back(m_w_strb);
            end else begin
               m_w_rdy = 1'b0;
               cnt++;
            end
         end else begin
            m_w_rdy = 1'b0;
            cnt = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [3:0] id, input logic [1:0] burst, output int hs_cyc);
      int t;
      @(negedge clk);
      s_arvalid = 1'b1; s_araddr = a; s_arlen = len; s_arsize = size; s_arid = id; s_arburst = burst;
      t = 0;
      while (!s_arready && t < 100) begin @(negedge clk); t++; end
      chk("ar_accept", 64'(s_arready), 64'd1);
      hs_cyc = cyc;
      @(posedge clk); #1;
      s_arvalid = 1'b0;
   endtask

   task automatic send_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [3:0] id);
      int t;
      @(negedge clk);
      s_awvalid = 1'b1; s_awaddr = a; s_awlen = len; s_awsize = size; s_awid = id; s_awburst = 2'b01;
      t = 0;
      while (!s_awready && t < 100) begin @(negedge clk); t++; end
      chk("aw_accept", 64'(s_awready), 64'd1);
      @(posedge clk); #1;
      s_awvalid = 1'b0;
   endtask

   task automatic send_w(input int n, input logic [3:0] id, input logic [3:0][7:0] strb,
                         input int last_at);
      int t;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         s_wvalid = 1'b1; s_wdata = wd_fn(id, i); s_wstrb = strb[i]; s_wlast = (i == last_at);
         t = 0;
         while (!s_wready && t < 100) begin @(negedge clk); t++; end
         chk("w_accept", 64'(s_wready), 64'd1);
         @(posedge clk); #1;
         s_wvalid = 1'b0; s_wlast = 1'b0;
      end
   endtask

   task automatic recv_b(input logic [3:0] id, input logic [1:0] resp);
      int t;
      @(negedge clk);
      t = 0;
      while (!s_bvalid && t < 100) begin @(negedge clk); t++; end
      chk("b_valid", 64'(s_bvalid), 64'd1);
      chk("b_id", 64'(s_bid), 64'(id));
      chk("b_resp", 64'(s_bresp), 64'(resp));
      s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
      @(negedge clk);
      chk("b_drop", 64'(s_bvalid), 64'd0);
   endtask

   task automatic rd_recv(input int n, input int hold, output int first_cyc);
      int t;
      logic [63:0] d0;
      logic        l0;
      first_cyc = -1;
      for (int b = 0; b < n; b++) begin
         t = 0;
         @(negedge clk);
         while (!s_rvalid && t < 200) begin @(negedge clk); t++; end
         if (!s_rvalid) begin
            chk("r_timeout", 64'(s_rvalid), 64'd1);
            return;
         end
         if (b == 0) first_cyc = cyc;
         if (b == 0 && hold > 0) begin
            d0 = s_rdata;
            l0 = s_rlast;
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               chk("r_hold_valid", 64'(s_rvalid), 64'd1);
               chk("r_hold_data", s_rdata, d0);
               chk("r_hold_last", 64'(s_rlast), 64'(l0));
            end
         end
         r_data_q.push_back(s_rdata);
         r_id_q.push_back(s_rid);
         r_resp_q.push_back(s_rresp);
         r_last_q.push_back(s_rlast);
         s_rready = 1'b1;
         @(posedge clk); #1;
         s_rready = 1'b0;
      end
   endtask

   task automatic clear_logs();
      mr_addr_q.delete(); mw_addr_q.delete(); mw_data_q.delete(); mw_strb_q.delete();
      r_data_q.delete(); r_id_q.delete(); r_resp_q.delete(); r_last_q.delete();
   endtask

   // Checks n collected R beats against expected addresses, id and response.
   task automatic check_reads(input int n, input logic [3:0][31:0] exp_a, input logic [63:0] d0,
                              input logic [3:0] id, input logic [1:0] resp, input bit mem_used);
      chk("r_beats", 64'(r_data_q.size()), 64'(n));
      chk("m_r_reqs", 64'(mr_addr_q.size()), mem_used ? 64'(n) : 64'd0);
      for (int b = 0; b < n && b < r_data_q.size(); b++) begin
         if (mem_used) begin
            if (b < mr_addr_q.size()) chk("m_r_addr", 64'(mr_addr_q[b]), 64'(exp_a[b]));
            chk("r_data", r_data_q[b], (b == 0) ? d0 : mem_fn(exp_a[b]));
         end
         chk("r_id", 64'(r_id_q[b]), 64'(id));
         chk("r_resp", 64'(r_resp_q[b]), 64'(resp));
         chk("r_last", 64'(r_last_q[b]), 64'(b == n - 1));
      end
   endtask

   typedef struct {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [3:0]       id;
      int               gap;
      logic [63:0]      exp_d0;
      logic [3:0][31:0] exp_a;
   } rd_vec_t;

   typedef struct {
      logic [31:0]      addr;
      logic [7:0]       len;
      logic [2:0]       size;
      logic [3:0]       id;
      int               gap;
      int               last_at;
      logic [3:0][7:0]  strb;
      logic [3:0][31:0] exp_a;
   } wr_vec_t;

   rd_vec_t rv[4];
   wr_vec_t wv[3];

   initial begin
      int hs, fc, n;

      rv[0] = '{32'h8000_0000, 8'd0, 3'd3, 4'd5, 0, 64'h1122_3344_5566_7788,
                {32'h0, 32'h0, 32'h0, 32'h8000_0000}};
      rv[1] = '{32'h0000_0100, 8'd3, 3'd2, 4'd3, 0, 64'hFFFF_FEFF_0000_0100,
                {32'h10C, 32'h108, 32'h104, 32'h100}};
      rv[2] = '{32'hFFFF_FFF8, 8'd1, 3'd3, 4'hA, 2, 64'h0000_0007_FFFF_FFF8,
                {32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFF8}};
      rv[3] = '{32'h0000_0040, 8'd2, 3'd0, 4'hF, 1, 64'hFFFF_FFBF_0000_0040,
                {32'h0, 32'h42, 32'h41, 32'h40}};

      wv[0] = '{32'h0000_0200, 8'd1, 3'd3, 4'd6, 0, 1, {8'h00, 8'h00, 8'h0F, 8'hFF},
                {32'h0, 32'h0, 32'h208, 32'h200}};
      wv[1] = '{32'hFFFF_FFFC, 8'd2, 3'd2, 4'd9, 2, 0, {8'h00, 8'h04, 8'h02, 8'h01},
                {32'h0, 32'h4, 32'h0, 32'hFFFF_FFFC}};
      wv[2] = '{32'h0000_1000, 8'd3, 3'd1, 4'hC, 0, 3, {8'h80, 8'h40, 8'h20, 8'h10},
                {32'h1006, 32'h1004, 32'h1002, 32'h1000}};

      rst_n = 1'b0;
      s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 2'b01;
      s_rready = 0;
      s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 2'b01;
      s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
      m_r_rdy = 0; m_re_valid = 1'b1; m_re_data = 0; m_w_rdy = 0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_arready", 64'(s_arready), 64'd1);
      chk("rst_awready", 64'(s_awready), 64'd1);
      chk("rst_rvalid", 64'(s_rvalid), 64'd0);
      chk("rst_wready", 64'(s_wready), 64'd0);
      chk("rst_bvalid", 64'(s_bvalid), 64'd0);
      chk("rst_m_r_req", 64'(m_r_req), 64'd0);
      chk("rst_m_w_req", 64'(m_w_req), 64'd0);
      rst_n = 1'b1;

      // Read vectors
      for (int v = 0; v < 4; v++) begin
         clear_logs();
         rd_gap = rv[v].gap;
         n = int'(rv[v].len) + 1;
         send_ar(rv[v].addr, rv[v].len, rv[v].size, rv[v].id, 2'b01, hs);
         rd_recv(n, 0, fc);
         if (rv[v].gap == 0) chk("rd_latency", 64'(fc - hs), 64'd3);
         check_reads(n, rv[v].exp_a, rv[v].exp_d0, rv[v].id, 2'b00, 1'b1);
         chk("m_r_size", 64'(m_r_size), 64'(rv[v].size));
      end

      // Write vectors
      for (int v = 0; v < 3; v++) begin
         clear_logs();
         wr_gap = wv[v].gap;
         n = int'(wv[v].len) + 1;
         send_aw(wv[v].addr, wv[v].len, wv[v].size, wv[v].id);
         send_w(n, wv[v].id, wv[v].strb, wv[v].last_at);
         recv_b(wv[v].id, 2'b00);
         chk("w_beats", 64'(mw_addr_q.size()), 64'(n));
         for (int b = 0; b < n && b < mw_addr_q.size(); b++) begin
            chk("m_w_addr", 64'(mw_addr_q[b]), 64'(wv[v].exp_a[b]));
            chk("m_w_data", mw_data_q[b], wd_fn(wv[v].id, b));
            chk("m_w_strb", 64'(mw_strb_q[b]), 64'(wv[v].strb[b]));
         end
      end

      // R backpressure with an overlapping write burst
      clear_logs();
      rd_gap = 0;
      wr_gap = 1;
      fork
         begin
            int h2, f2;
            send_ar(32'h300, 8'd1, 3'd3, 4'd2, 2'b01, h2);
            rd_recv(2, 5, f2);
         end
         begin
            send_aw(32'h200, 8'd1, 3'd3, 4'd6);
            send_w(2, 4'd6, wv[0].strb, 1);
            recv_b(4'd6, 2'b00);
         end
      join
      check_reads(2, {32'h0, 32'h0, 32'h308, 32'h300}, mem_fn(32'h300), 4'd2, 2'b00, 1'b1);
      chk("cc_w_beats", 64'(mw_addr_q.size()), 64'd2);
      if (mw_addr_q.size() == 2) begin
         chk("cc_w_addr1", 64'(mw_addr_q[1]), 64'h208);
         chk("cc_w_strb1", 64'(mw_strb_q[1]), 64'h0F);
      end

      // Burst type handling: WRAP, len 1
      clear_logs();
      wr_gap = 0;
      send_ar(32'h600, 8'd1, 3'd3, 4'd4, 2'b10, hs);
      rd_recv(2, 0, fc);
`ifdef AXI2MEM_SLVERR_EN
      check_reads(2, '0, 64'd0, 4'd4, 2'b10, 1'b0);
`else
      check_reads(2, {32'h0, 32'h0, 32'h608, 32'h600}, mem_fn(32'h600), 4'd4, 2'b00, 1'b1);
`endif

      // Reset during beat 2 of 4
      clear_logs();
      send_ar(32'h500, 8'd3, 3'd3, 4'd7, 2'b01, hs);
      rd_recv(1, 0, fc);
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!s_rvalid && t < 100) begin @(negedge clk); t++; end
         chk("mid_rvalid", 64'(s_rvalid), 64'd1);
      end
      rst_n = 1'b0;
      #1;
      chk("mr_arready", 64'(s_arready), 64'd1);
      chk("mr_awready", 64'(s_awready), 64'd1);
      chk("mr_rvalid", 64'(s_rvalid), 64'd0);
      chk("mr_rlast", 64'(s_rlast), 64'd0);
      chk("mr_rdata", s_rdata, 64'd0);
      chk("mr_rid", 64'(s_rid), 64'd0);
      chk("mr_m_r_req", 64'(m_r_req), 64'd0);
      chk("mr_m_r_addr", 64'(m_r_addr), 64'd0);
      chk("mr_wready", 64'(s_wready), 64'd0);
      chk("mr_m_w_req", 64'(m_w_req), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_logs();
      send_ar(rv[0].addr, rv[0].len, rv[0].size, rv[0].id, 2'b01, hs);
      rd_recv(1, 0, fc);
      chk("post_rst_latency", 64'(fc - hs), 64'd3);
      check_reads(1, rv[0].exp_a, rv[0].exp_d0, rv[0].id, 2'b00, 1'b1);
      repeat (3) @(negedge clk);
      chk("post_rst_rvalid", 64'(s_rvalid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
